// File: rtl/wn_axis_packet_source.sv
`default_nettype none
// ============================================================================
// Module      : wn_axis_packet_source
// Description : AXI-Stream packet generator. A start pulse launches a run of
//               cfg_num_pkts packets, each cfg_len beats long, separated by
//               cfg_gap idle cycles. tdata increments on every accepted beat
//               across the whole run, tuser carries the packet index, and
//               tlast marks the final beat of each packet. tready
//               backpressure is honoured: the presented beat is held stable
//               until it is accepted.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock          in   1     rising-edge clock
//   reset          in   1     asynchronous, active-high reset
//   start          in   1     one-cycle run request (IDLE/DONE only)
//   cfg_len        in   LENW  beats per packet (0 behaves as 1)
//   cfg_num_pkts   in   8     packets per run (0 suppresses the start)
//   cfg_gap        in   GAPW  tvalid-low cycles between packets
//   cfg_seed       in   DW    tdata of the first beat of the run
//   output_tvalid  out  1     beat valid
//   output_tready  in   1     sink ready
//   output_tdata   out  DW    beat data
//   output_tuser   out  UW    packet index (modulo 2^UW)
//   output_tlast   out  1     final beat of packet
//   busy           out  1     run in progress
//   done           out  1     one-cycle pulse at end of run
// ============================================================================
module wn_axis_packet_source #(
    parameter int DW   = 8,
    parameter int UW   = 8,
    parameter int LENW = 8,
    parameter int GAPW = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [LENW-1:0] cfg_len,
    input  logic [7:0]      cfg_num_pkts,
    input  logic [GAPW-1:0] cfg_gap,
    input  logic [DW-1:0]   cfg_seed,
    output logic            output_tvalid,
    input  logic            output_tready,
    output logic [DW-1:0]   output_tdata,
    output logic [UW-1:0]   output_tuser,
    output logic            output_tlast,
    output logic            busy,
    output logic            done
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q,   state_d;

    // Run configuration captured at start; later cfg_* changes are ignored.
    logic [LENW-1:0] len_m1_q,  len_m1_d;     // last beat index of a packet
    logic [7:0]      num_m1_q,  num_m1_d;     // last packet index of the run
    logic [GAPW-1:0] gap_q,     gap_d;

    // Progress counters
    logic [LENW-1:0] beat_q,    beat_d;
    logic [7:0]      pkt_q,     pkt_d;
    logic [GAPW-1:0] gap_cnt_q, gap_cnt_d;

    // Registered stream / status outputs
    logic            tvalid_q,  tvalid_d;
    logic [DW-1:0]   tdata_q,   tdata_d;
    logic [UW-1:0]   tuser_q,   tuser_d;
    logic            tlast_q,   tlast_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;

    // Helper terms
    logic            w_hs;
    logic            w_start_ok;
    logic            w_last_pkt;
    logic            w_adv_pkt;
    logic [LENW-1:0] w_beat_inc;
    logic [LENW-1:0] w_cfg_len_m1;

    assign w_hs         = tvalid_q & output_tready;
    assign w_start_ok   = start & (cfg_num_pkts != 8'd0);
    assign w_last_pkt   = (pkt_q == num_m1_q);
    assign w_beat_inc   = beat_q + LENW'(1);
    // A zero length is treated as a one-beat packet.
    assign w_cfg_len_m1 = (cfg_len == '0) ? '0 : (cfg_len - LENW'(1));

    // Moving on to beat 0 of the next packet happens either straight off a
    // tlast handshake (no gap) or at the end of the final gap cycle.
    assign w_adv_pkt = ((state_q == S_SEND) & w_hs & tlast_q & ~w_last_pkt
                        & (gap_q == '0))
                     | ((state_q == S_GAP) & (gap_cnt_q <= GAPW'(1)));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            // DONE accepts a new start, exactly like IDLE.
            S_IDLE, S_DONE: begin
                state_d = w_start_ok ? S_SEND : S_IDLE;
            end
            S_SEND: begin
                if (w_hs && tlast_q) begin
                    if (w_last_pkt) begin
                        state_d = S_DONE;
                    end else if (gap_q != '0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= GAPW'(1)) begin
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        len_m1_d  = len_m1_q;
        num_m1_d  = num_m1_q;
        gap_d     = gap_q;
        beat_d    = beat_q;
        pkt_d     = pkt_q;
        gap_cnt_d = gap_cnt_q;
        tdata_d   = tdata_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;

        // Status and tvalid follow the state being entered, so they are
        // registered without any combinational path from tready.
        tvalid_d  = (state_d == S_SEND);
        busy_d    = (state_d == S_SEND) || (state_d == S_GAP);
        done_d    = (state_d == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    len_m1_d  = w_cfg_len_m1;
                    num_m1_d  = cfg_num_pkts - 8'd1;
                    gap_d     = cfg_gap;
                    beat_d    = '0;
                    pkt_d     = '0;
                    gap_cnt_d = '0;
                    tdata_d   = cfg_seed;
                    tuser_d   = '0;
                    tlast_d   = (w_cfg_len_m1 == '0);
                end
            end
            S_SEND: begin
                if (w_hs) begin
                    if (!tlast_q) begin
                        beat_d  = w_beat_inc;
                        tdata_d = tdata_q + DW'(1);
                        tlast_d = (w_beat_inc == len_m1_q);
                    end else if (!w_last_pkt && (gap_q != '0)) begin
                        // Data fields keep their last values while idle.
                        gap_cnt_d = gap_q;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - GAPW'(1);
            end
            default: begin
            end
        endcase

        // Beat 0 of the next packet; data keeps counting across packets.
        if (w_adv_pkt) begin
            beat_d    = '0;
            pkt_d     = pkt_q + 8'd1;
            gap_cnt_d = '0;
            tdata_d   = tdata_q + DW'(1);
            tuser_d   = tuser_q + UW'(1);
            tlast_d   = (len_m1_q == '0);
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_m1_q  <= '0;
            num_m1_q  <= '0;
            gap_q     <= '0;
            beat_q    <= '0;
            pkt_q     <= '0;
            gap_cnt_q <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tuser_q   <= '0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            len_m1_q  <= len_m1_d;
            num_m1_q  <= num_m1_d;
            gap_q     <= gap_d;
            beat_q    <= beat_d;
            pkt_q     <= pkt_d;
            gap_cnt_q <= gap_cnt_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tuser_q   <= tuser_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign output_tvalid = tvalid_q;
    assign output_tdata  = tdata_q;
    assign output_tuser  = tuser_q;
    assign output_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_wn_axis_packet_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_wn_axis_packet_source
// Description : Directed self-checking bench for wn_axis_packet_source.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wn_axis_packet_source;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] cfg_len;
    logic [7:0] cfg_num_pkts;
    logic [3:0] cfg_gap;
    logic [7:0] cfg_seed;
    logic       output_tvalid;
    logic       output_tready;
    logic [7:0] output_tdata;
    logic [7:0] output_tuser;
    logic       output_tlast;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;
    int hs_count = 0;
    int hs_base;

    wn_axis_packet_source #(
        .DW   (8),
        .UW   (8),
        .LENW (8),
        .GAPW (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .cfg_len       (cfg_len),
        .cfg_num_pkts  (cfg_num_pkts),
        .cfg_gap       (cfg_gap),
        .cfg_seed      (cfg_seed),
        .output_tvalid (output_tvalid),
        .output_tready (output_tready),
        .output_tdata  (output_tdata),
        .output_tuser  (output_tuser),
        .output_tlast  (output_tlast),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (output_tvalid && output_tready) hs_count++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] d, input logic [7:0] u,
                            input logic l);
        chk({tag, ".tvalid"}, {31'd0, output_tvalid}, 32'd1);
        chk({tag, ".tdata"},  {24'd0, output_tdata},  {24'd0, d});
        chk({tag, ".tuser"},  {24'd0, output_tuser},  {24'd0, u});
        chk({tag, ".tlast"},  {31'd0, output_tlast},  {31'd0, l});
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, ".tvalid"}, {31'd0, output_tvalid}, 32'd0);
        chk({tag, ".busy"},   {31'd0, busy},          32'd0);
        chk({tag, ".done"},   {31'd0, done},          {31'd0, exp_done});
    endtask

    task automatic start_run(input logic [7:0] seed, input logic [7:0] len,
                             input logic [7:0] num, input logic [3:0] gap);
        cfg_seed     = seed;
        cfg_len      = len;
        cfg_num_pkts = num;
        cfg_gap      = gap;
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        cfg_len       = 8'd0;
        cfg_num_pkts  = 8'd0;
        cfg_gap       = 4'd0;
        cfg_seed      = 8'd0;
        output_tready = 1'b1;

        // Reset state
        step();
        step();
        chk_idle("rst", 1'b0);
        chk("rst.tdata", {24'd0, output_tdata}, 32'd0);
        chk("rst.tlast", {31'd0, output_tlast}, 32'd0);
        reset = 1'b0;
        step();
        chk_idle("post_rst", 1'b0);

        // 1: seed 10, len 4, single packet; cfg changes mid-run are ignored
        start_run(8'h10, 8'd4, 8'd1, 4'd0);
        chk("t1.busy", {31'd0, busy}, 32'd1);
        chk_beat("t1.b0", 8'h10, 8'd0, 1'b0);
        cfg_seed = 8'hAA;
        cfg_len  = 8'd9;
        step(); chk_beat("t1.b1", 8'h11, 8'd0, 1'b0);
        step(); chk_beat("t1.b2", 8'h12, 8'd0, 1'b0);
        step(); chk_beat("t1.b3", 8'h13, 8'd0, 1'b1);
        step(); chk_idle("t1.done", 1'b1);
        step(); chk_idle("t1.after", 1'b0);

        // 2: seed 0, len 3, two packets, gap 2
        start_run(8'h00, 8'd3, 8'd2, 4'd2);
        chk_beat("t2.p0b0", 8'h00, 8'd0, 1'b0);
        step(); chk_beat("t2.p0b1", 8'h01, 8'd0, 1'b0);
        step(); chk_beat("t2.p0b2", 8'h02, 8'd0, 1'b1);
        step();
        chk("t2.gap1.tvalid", {31'd0, output_tvalid}, 32'd0);
        chk("t2.gap1.busy",   {31'd0, busy},          32'd1);
        chk("t2.gap1.tdata",  {24'd0, output_tdata},  32'h02);
        step();
        chk("t2.gap2.tvalid", {31'd0, output_tvalid}, 32'd0);
        step(); chk_beat("t2.p1b0", 8'h03, 8'd1, 1'b0);
        step(); chk_beat("t2.p1b1", 8'h04, 8'd1, 1'b0);
        step(); chk_beat("t2.p1b2", 8'h05, 8'd1, 1'b1);
        step(); chk_idle("t2.done", 1'b1);
        step();

        // 3: len 5, sink stalls 3 cycles with beat 2 presented
        hs_base = hs_count;
        start_run(8'h40, 8'd5, 8'd1, 4'd0);
        chk_beat("t3.b0", 8'h40, 8'd0, 1'b0);
        step(); chk_beat("t3.b1", 8'h41, 8'd0, 1'b0);
        step(); chk_beat("t3.b2", 8'h42, 8'd0, 1'b0);
        output_tready = 1'b0;
        step(); chk_beat("t3.stall1", 8'h42, 8'd0, 1'b0);
        step(); chk_beat("t3.stall2", 8'h42, 8'd0, 1'b0);
        step(); chk_beat("t3.stall3", 8'h42, 8'd0, 1'b0);
        output_tready = 1'b1;
        step(); chk_beat("t3.b3", 8'h43, 8'd0, 1'b0);
        step(); chk_beat("t3.b4", 8'h44, 8'd0, 1'b1);
        step(); chk_idle("t3.done", 1'b1);
        chk("t3.hs_count", hs_count - hs_base, 32'd5);
        step();

        // 4: tdata wraps
        start_run(8'hFE, 8'd4, 8'd1, 4'd0);
        chk_beat("t4.b0", 8'hFE, 8'd0, 1'b0);
        step(); chk_beat("t4.b1", 8'hFF, 8'd0, 1'b0);
        step(); chk_beat("t4.b2", 8'h00, 8'd0, 1'b0);
        step(); chk_beat("t4.b3", 8'h01, 8'd0, 1'b1);
        step(); chk_idle("t4.done", 1'b1);
        step();

        // 5: zero length -> single-beat packets; start mid-run ignored
        start_run(8'h70, 8'd0, 8'd3, 4'd0);
        chk_beat("t5.p0", 8'h70, 8'd0, 1'b1);
        cfg_seed = 8'h99;
        start    = 1'b1;
        step();
        start    = 1'b0;
        chk_beat("t5.p1", 8'h71, 8'd1, 1'b1);
        step(); chk_beat("t5.p2", 8'h72, 8'd2, 1'b1);
        step(); chk_idle("t5.done", 1'b1);
        step(); chk_idle("t5.idle", 1'b0);
        step(); chk_idle("t5.idle2", 1'b0);

        // 5b: zero packet count suppresses start
        start_run(8'h55, 8'd2, 8'd0, 4'd0);
        chk_idle("t5b.noop", 1'b0);
        step(); chk_idle("t5b.noop2", 1'b0);

        // 6: async reset mid-packet, then clean restart
        start_run(8'h30, 8'd4, 8'd2, 4'd0);
        chk_beat("t6.b0", 8'h30, 8'd0, 1'b0);
        step(); chk_beat("t6.b1", 8'h31, 8'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("t6.async_rst", 1'b0);
        chk("t6.rst.tdata", {24'd0, output_tdata}, 32'd0);
        chk("t6.rst.tuser", {24'd0, output_tuser}, 32'd0);
        chk("t6.rst.tlast", {31'd0, output_tlast}, 32'd0);
        step();
        reset = 1'b0;
        step(); chk_idle("t6.released", 1'b0);
        start_run(8'h20, 8'd2, 8'd1, 4'd0);
        chk_beat("t6.r0", 8'h20, 8'd0, 1'b0);
        step(); chk_beat("t6.r1", 8'h21, 8'd0, 1'b1);
        step(); chk_idle("t6.done", 1'b1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
